// File: rtl/cnt_ld_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnt_ld_pkg
// Description : Shared types and constants for the counter-sharing arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cnt_ld_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Number of requesters sharing the counter.
    localparam int NREQ = 2;

endpackage : cnt_ld_pkg
`default_nettype wire

// File: rtl/cnt_ld_sync.sv
`default_nettype none
// ============================================================================
// Module      : cnt_ld_sync
// Description : Loadable up-counter with synchronous active-high reset.
//               Load takes priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_ld_sync #(
    parameter int N = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         en,
    input  logic         ld,
    input  logic [N-1:0] D,
    output logic [N-1:0] q
);

    // Counter register: reset, then load, then increment.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q <= '0;
        end else if (ld) begin
            q <= D;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

endmodule : cnt_ld_sync
`default_nettype wire

// File: rtl/cnt_ld_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cnt_ld_arbiter
// Description : Round-robin arbiter sharing one loadable up-counter between
//               two requesters. The winner's start value is loaded, counted
//               up to all-ones, and completion is pulsed back to it.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_ld_arbiter
    import cnt_ld_pkg::*;
#(
    parameter int N = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [NREQ-1:0] req,
    input  logic [N-1:0]    D0,
    input  logic [N-1:0]    D1,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic            busy,
    output logic [N-1:0]    q
);

    localparam logic [N-1:0] c_term = '1;

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic            r_last;   // index of the most recently served/aborted requester
    logic            r_g;      // index of the currently granted requester
    logic [N-1:0]    r_dsel;   // start value captured at grant
    logic            w_ld;
    logic            w_en;
    logic            w_win;
    logic            w_term;
    logic            w_req_g;

    // Both requesting: take the one not served last; otherwise the only one.
    assign w_win   = (req == 2'b11) ? ~r_last : req[1];
    assign w_term  = (q == c_term);
    assign w_req_g = req[r_g];

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and counter-control decode; an aborting requester suppresses
    // load and enable so q keeps its present value.
    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        w_en        = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (!w_req_g) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_ld        = 1'b1;
                    w_state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (!w_req_g) begin
                    w_state_nxt = IDLE;
                end else if (w_term) begin
                    w_state_nxt = DONE;
                end else begin
                    w_en = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant, completion pulse, round-robin pointer and start-value capture.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_gnt  <= '0;
            r_done <= '0;
            r_last <= 1'b1;
            r_g    <= 1'b0;
            r_dsel <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_g    <= w_win;
                        r_gnt  <= w_win ? 2'b10 : 2'b01;
                        r_dsel <= w_win ? D1 : D0;
                    end
                end
                LOAD, COUNT: begin
                    if (!w_req_g) begin
                        r_gnt  <= '0;
                        r_last <= r_g;
                    end else if ((r_state == COUNT) && w_term) begin
                        r_gnt <= '0;
                    end
                end
                DONE: begin
                    r_done <= r_g ? 2'b10 : 2'b01;
                    r_last <= r_g;
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    cnt_ld_sync #(
        .N (N)
    ) u_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (w_en),
        .ld    (w_ld),
        .D     (r_dsel),
        .q     (q)
    );

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = (r_state != IDLE);

endmodule : cnt_ld_arbiter
`default_nettype wire

// File: doc/cnt_ld_arbiter.md
# cnt_ld_arbiter

Round-robin arbiter and sequencer that shares one loadable up-counter between two requesters. A requester asks for an interval by presenting a start value. The block grants the counter, loads the start value, and counts up to the all-ones terminal value. It then signals completion to the granted requester. It sits between the counter datapath and the interval-timing clients, and is the only agent that drives the counter's load and enable.

## Interface
- `N`, 4, counter and start-value width; terminal value is all-ones (`2^N-1`)
- `Clk` in 1 — single clock; all state changes on rising edge
- `Reset` in 1 — synchronous, active-high
- `req` in 2 — per-requester request level; must be held until `done` or abort
- `D0` in N — start value of requester 0, sampled at grant
- `D1` in N — start value of requester 1, sampled at grant
- `gnt` out 2 — one-hot grant, at most one bit high
- `done` out 2 — one-cycle completion pulse to the served requester
- `busy` out 1 — high whenever state ≠ IDLE
- `q` out N — counter value

## Operation
- FSM states: IDLE, LOAD, COUNT, DONE.
- IDLE
  - If any `req` bit is high, select the winner by round-robin. Latch the winner's D into `dsel` and set `gnt`. Next state is LOAD.
  - If no request, hold.
- LOAD
  - Drive counter `ld` for one cycle, so `q ← dsel`. Next state is COUNT.
- COUNT
  - If `q ≠ 2^N-1`: counter `en=1`, `q` increments by 1.
  - If `q = 2^N-1`: `en=0` and next state is DONE.
  - `q` never wraps.
- DONE
  - `done[g]=1` for this cycle only; `gnt=00`.
  - Update the round-robin pointer `last ← g`. Next state is IDLE.
- Round-robin
  - With both requests high in IDLE, grant the requester ≠ `last`.
  - With a single request, grant it regardless of `last`.
- Abort
  - The granted `req` bit going low during LOAD or COUNT sends the block to IDLE on the next edge.
  - `gnt=00`, no `done`, `last ← g`. `q` holds its current value.
- The non-granted requester's `req` and D are ignored while busy.
- After any completion or abort, IDLE lasts at least one cycle before the next grant.

## Timing
- Reset values: state=IDLE, `q=0`, `gnt=00`, `done=00`, `busy=0`, `last=1`, so requester 0 wins first.
- Reset is synchronous and overrides every state, including mid-COUNT. Outputs take their reset values at the first edge with `Reset=1`.
- Edge numbering: edge 0 is the first edge with `req` seen in IDLE.
  - Edge 0: `gnt` and `busy` high.
  - Edge 1: `q=D`.
  - One increment per edge follows until `q=2^N-1`.
  - The next edge enters DONE.
- `done` becomes visible after edge `2^N − D + 2`:
  - N=4, D=13: 5 edges.
  - D=15: 3 edges.
  - D=0: 18 edges.
- `q` holds the terminal value after DONE until the next LOAD or reset.
- `done` and `gnt` are never high in the same cycle.
- `req` dropping in the DONE cycle has no effect.

## Structure
- Package `cnt_ld_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} arb_state_t`
  - `localparam int NREQ = 2`
- Sub-module `cnt_ld_sync` holds the loadable counter.
  - Ports: `Clk`, `Reset`, `en`, `ld`, `D`, `q`.
  - Synchronous active-high reset; `ld` has priority over `en`.
- Top level holds the FSM, round-robin pointer, `dsel` register, and terminal compare.

## Test plan
- Reset held 2 cycles → `q=0`, `gnt=00`, `done=00`, `busy=0`.
- Only `req[0]` with `D0=4'hD`:
  - `gnt=01` after edge 0, `q` = 13, 14, 15.
  - `done=01` for exactly one cycle after edge 5.
  - `q` stays 15 afterwards.
- From reset, `req=11` with `D0=4'hE`, `D1=4'hC`:
  - Requester 0 is served first and `done[0]` pulses.
  - After one IDLE cycle, `gnt=10`, `q` counts 12 to 15, and `done[1]` pulses.
- Boundaries:
  - `D0=4'hF` → `done[0]` after 3 edges, `q` never exceeds 15.
  - `D0=4'h0` → `done[0]` after 18 edges.
- Abort: `req[1]` granted with `D1=4'h3`, dropped when `q=5`:
  - Next edge gives IDLE, `gnt=00`, `q=5` held, no `done`.
  - A following `req=11` grants requester 0.
- `Reset` asserted mid-COUNT (`q=9`) → next edge gives `q=0`, IDLE, `gnt=00`. After release, `req=11` grants requester 0.
